// File: rtl/sumador_arbiter.sv
// sumador_arbiter: shares one start/done adder between two requesters.
// Round-robin grant on ties, operands latched at grant, one transaction
// in flight; a done that never comes is aborted after TIMEOUT wait cycles.
module sumador_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_start,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  input  logic             add_done,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_err,
  output logic             busy
);

  // Timer counts WAIT cycles 0 .. TIMEOUT-1; the last value is the abort point.
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state_reg;
  logic             grant_reg;    // id of the requester owning the transaction
  logic             last_id_reg;  // id served most recently, loses the next tie
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             err_reg;
  logic [TW-1:0]    timer_reg;

  logic grant_any;
  logic grant_id;

  // Grant decision: only in IDLE; a tie goes to the requester not served last.
  always_comb begin
    grant_any = (state_reg == ST_IDLE) && !rst && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      grant_id = ~last_id_reg;
    end else begin
      grant_id = req1_valid;
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any &&  grant_id;

  // Transaction FSM: grant/latch, start pulse, bounded wait, one-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= 1'b0;
      last_id_reg <= 1'b1;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
      err_reg     <= 1'b0;
      timer_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            grant_reg <= grant_id;
            a_reg     <= grant_id ? req1_a : req0_a;
            b_reg     <= grant_id ? req1_b : req0_b;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A done seen here belongs to nobody and is dropped.
          timer_reg <= '0;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (add_done) begin
            // Done wins even on the abort cycle.
            sum_reg   <= add_sum;
            cout_reg  <= add_cout;
            err_reg   <= 1'b0;
            state_reg <= ST_RESP;
          end else if (timer_reg == TIMER_LAST) begin
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            timer_reg <= timer_reg + TW'(1);
          end
        end
        ST_RESP: begin
          last_id_reg <= grant_reg;
          state_reg   <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Adder side: operands only while the adder owns the transaction.
  assign add_start = (state_reg == ST_ISSUE);
  assign add_a     = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) ? a_reg : '0;
  assign add_b     = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) ? b_reg : '0;

  // Response side: shared result bus is zero outside the RESP cycle.
  assign rsp0_valid = (state_reg == ST_RESP) && !grant_reg;
  assign rsp1_valid = (state_reg == ST_RESP) &&  grant_reg;
  assign rsp_sum    = (state_reg == ST_RESP) ? sum_reg : '0;
  assign rsp_cout   = (state_reg == ST_RESP) && cout_reg;
  assign rsp_err    = (state_reg == ST_RESP) && err_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule
